// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: ALU opcodes, MIPS opcode/funct codes, issue FSM
// states and the decoder result record.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_e;
  typedef enum logic       {A_RS, A_RT} a_sel_e;
  typedef enum logic       {B_RT, B_IMM} b_sel_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_SHAMT} ext_e;

  typedef struct packed {
    logic [2:0] alu_op;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    ext_e       ext_mode;
    logic [4:0] dest_addr;
    logic       legal;
  } dec_t;

  // shamt sits in imm16[10:6], so one immediate field covers every B-immediate form
  function automatic logic [31:0] ext_imm(ext_e mode, logic [15:0] imm);
    case (mode)
      EXT_SIGN: ext_imm = {{16{imm[15]}}, imm};
      EXT_ZERO: ext_imm = {16'h0000, imm};
      default:  ext_imm = {27'd0, imm[10:6]};
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS-subset decoder: instruction word -> ALU opcode, operand
// selects, immediate extension mode, destination register and legality.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opcode, funct;
  logic       unused_rs;

  assign opcode    = instr_i[31:26];
  assign funct     = instr_i[5:0];
  assign unused_rs = ^instr_i[25:21];

  always_comb begin
    dec_o           = '0;
    dec_o.a_sel     = A_RS;
    dec_o.b_sel     = B_IMM;
    dec_o.ext_mode  = EXT_SIGN;
    dec_o.dest_addr = instr_i[20:16];
    dec_o.legal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec_o.dest_addr = instr_i[15:11];
        dec_o.b_sel     = B_RT;
        case (funct)
          FN_ADD, FN_ADDU: dec_o.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_o.alu_op = ALU_SUB;
          FN_SLTU:         dec_o.alu_op = ALU_SLTU;
          FN_SLT:          dec_o.alu_op = ALU_SLT;
          FN_OR:           dec_o.alu_op = ALU_OR;
          FN_AND:          dec_o.alu_op = ALU_AND;
          FN_SLL, FN_SRL: begin
            // shifts move rt by the shamt field
            dec_o.alu_op   = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            dec_o.a_sel    = A_RT;
            dec_o.b_sel    = B_IMM;
            dec_o.ext_mode = EXT_SHAMT;
          end
          default: dec_o.legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: dec_o.alu_op = ALU_ADD;
      OP_SLTI:           dec_o.alu_op = ALU_SLT;
      OP_SLTIU:          dec_o.alu_op = ALU_SLTU;
      OP_ORI: begin
        dec_o.alu_op   = ALU_OR;
        dec_o.ext_mode = EXT_ZERO;
      end
      OP_ANDI: begin
        dec_o.alu_op   = ALU_AND;
        dec_o.ext_mode = EXT_ZERO;
      end
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue FSM in front of the combinational ALU: accept, decode and
// read operands, execute, write back. All outputs are registered.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              illegal
);

  state_e              state_q;
  logic [31:0]         instr_q;
  logic [REG_AW-1:0]   rs_addr_q, rt_addr_q, dest_q, wb_addr_q;
  logic [2:0]          alu_op_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q, wb_data_q;
  logic                ready_q, wb_en_q, done_q, illegal_q;
  dec_t                dec;
  logic [DATA_W-1:0]   imm_ext;

  alu_decode u_dec (.instr_i(instr_q), .dec_o(dec));

  assign imm_ext = ext_imm(dec.ext_mode, instr_q[15:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dest_q    <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      ready_q   <= 1'b1;
      wb_en_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wb_en_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          instr_q   <= instr;
          rs_addr_q <= instr[25:21];
          rt_addr_q <= instr[20:16];
          ready_q   <= 1'b0;
          state_q   <= DECODE;
        end
        DECODE: if (dec.legal) begin
          // regfile data for the registered addresses is valid this cycle
          alu_op_q <= dec.alu_op;
          alu_a_q  <= (dec.a_sel == A_RT) ? rt_data : rs_data;
          alu_b_q  <= (dec.b_sel == B_IMM) ? imm_ext : rt_data;
          dest_q   <= dec.dest_addr;
          state_q  <= EXECUTE;
        end else begin
          illegal_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        EXECUTE: begin
          wb_data_q <= alu_result;
          wb_addr_q <= dest_q;
          wb_en_q   <= (dest_q != '0);
          done_q    <= 1'b1;
          state_q   <= WRITEBACK;
        end
        WRITEBACK: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rs_addr     = rs_addr_q;
  assign rt_addr     = rt_addr_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus queues instruction-level
// expectations, a negedge monitor checks timing, pulses and write-back values.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [31:0] rs_data, rt_data, alu_a, alu_b, alu_result, wb_data;
  logic [2:0]  alu_op;
  logic        wb_en, done, illegal;

  logic [31:0] rf [32];
  int tests = 0, fails = 0, cyc = 0, accepts = 0;
  logic rcheck = 1'b0;

  typedef struct {
    bit          legal;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          t;
  } exp_t;
  exp_t pend_q[$], infl_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  // stand-in for the 32-bit combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = {31'd0, alu_a < alu_b};
      3'd3: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd4: alu_result = alu_a << alu_b;
      3'd5: alu_result = alu_a >> alu_b;
      3'd6: alu_result = alu_a | alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // instruction semantics straight from the MIPS meaning of each mnemonic
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [31:0] rs, rt, simm, zimm, sh;
    rs   = rf[ins[25:21]];
    rt   = rf[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    sh   = {27'd0, ins[10:6]};
    e = '{legal: 1'b1, dest: ins[20:16], op: 3'd0, a: rs, b: rt, res: 32'd0, t: 0};
    case (ins[31:26])
      6'h00: begin
        e.dest = ins[15:11];
        case (ins[5:0])
          6'h20, 6'h21: begin e.op = 3'd0; e.res = rs + rt; end
          6'h22, 6'h23: begin e.op = 3'd1; e.res = rs - rt; end
          6'h2B: begin e.op = 3'd2; e.res = (rs < rt) ? 32'd1 : 32'd0; end
          6'h2A: begin e.op = 3'd3; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
          6'h25: begin e.op = 3'd6; e.res = rs | rt; end
          6'h24: begin e.op = 3'd7; e.res = rs & rt; end
          6'h00: begin e.op = 3'd4; e.a = rt; e.b = sh; e.res = rt << ins[10:6]; end
          6'h02: begin e.op = 3'd5; e.a = rt; e.b = sh; e.res = rt >> ins[10:6]; end
          default: e.legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin e.op = 3'd0; e.b = simm; e.res = rs + simm; end
      6'h0A: begin e.op = 3'd3; e.b = simm; e.res = ($signed(rs) < $signed(simm)) ? 32'd1 : 32'd0; end
      6'h0B: begin e.op = 3'd2; e.b = simm; e.res = (rs < simm) ? 32'd1 : 32'd0; end
      6'h0D: begin e.op = 3'd6; e.b = zimm; e.res = rs | zimm; end
      6'h0C: begin e.op = 3'd7; e.b = zimm; e.res = rs & zimm; end
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  // monitor: checks every cycle against the in-flight expectation
  always @(negedge clk) begin
    bit er, ed, ei, ew;
    exp_t e;
    if (rst) begin
      infl_q.delete();
      pend_q.delete();
      rcheck <= 1'b1;
    end else begin
      if (rcheck) begin
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rcheck <= 1'b0;
      end
      er = 1'b1; ed = 1'b0; ei = 1'b0; ew = 1'b0;
      if (infl_q.size() > 0) begin
        e  = infl_q[0];
        er = cyc >= e.t + (e.legal ? 4 : 2);
        ed = e.legal && (cyc == e.t + 3);
        ei = !e.legal && (cyc == e.t + 2);
        ew = ed && (e.dest != 5'd0);
        if (e.legal && cyc == e.t + 2) begin
          chk("exec_alu_op", {29'd0, alu_op}, {29'd0, e.op});
          chk("exec_alu_a", alu_a, e.a);
          chk("exec_alu_b", alu_b, e.b);
        end
      end
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, er});
      chk("done", {31'd0, done}, {31'd0, ed});
      chk("illegal", {31'd0, illegal}, {31'd0, ei});
      chk("wb_en", {31'd0, wb_en}, {31'd0, ew});
      if (ew) begin
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.dest});
        chk("wb_data", wb_data, e.res);
      end
      if (ed || ei) void'(infl_q.pop_front());
      if (instr_valid && instr_ready) begin
        accepts++;
        if (pend_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL accept: got unexpected accept expected none (cycle %0d)", cyc);
        end else begin
          e = pend_q.pop_front();
          e.t = cyc;
          infl_q.push_back(e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input bit keep);
    int n = 0;
    pend_q.push_back(model(ins));
    instr = ins;
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 40);
    if (!instr_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 40 cycles");
    end
    @(posedge clk); #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (pend_q.size() == 0 && infl_q.size() == 0) break;
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [12];
    logic [5:0] ol [8];
    logic [31:0] w;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2B, 6'h2A, 6'h25, 6'h24, 6'h00, 6'h02, 6'h01, 6'h27};
    ol = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0C, 6'h23, 6'h0F};
    w = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      w[31:26] = 6'h00;
      w[5:0]   = fl[$urandom_range(0, 11)];
    end else begin
      w[31:26] = ol[$urandom_range(0, 7)];
    end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // addu $3,$1,$2: 5 + 0xFFFFFFFF wraps to 4
    rf[1] = 32'h5; rf[2] = 32'hFFFF_FFFF;
    issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 1'b0);
    wait_idle();
    rf[1] = 32'h8000_0000;
    issue({6'h0A, 5'd1, 5'd4, 16'hFFFF}, 1'b0);  // slti $4,$1,-1
    wait_idle();
    issue({6'h0D, 5'd1, 5'd6, 16'h8000}, 1'b0);  // ori $6,$1,0x8000
    wait_idle();
    rf[2] = 32'h1;
    issue({6'h00, 5'd0, 5'd2, 5'd5, 5'd4, 6'h00}, 1'b0);  // sll $5,$2,4
    wait_idle();
    issue({6'h23, 5'd1, 5'd2, 16'h0010}, 1'b0);  // lw: illegal
    wait_idle();
    issue({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 1'b0);  // addu $0
    wait_idle();

    // reset landing in EXECUTE discards the add
    issue({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20}, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // three back-to-back with valid held high
    accepts = 0;
    rf[1] = 32'h1234_5678; rf[2] = 32'h0F0F_0F0F;
    issue({6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h22}, 1'b1);
    issue({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h24}, 1'b1);
    issue({6'h00, 5'd0, 5'd2, 5'd10, 5'd3, 6'h02}, 1'b0);
    wait_idle();
    chk("b2b_accepts", 32'(accepts), 32'd3);

    for (int k = 0; k < 80; k++) begin
      for (int r = 1; r < 32; r++)
        if ($urandom_range(0, 3) == 0) rf[r] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      issue(rand_instr(), 1'b0);
      if ($urandom_range(0, 2) == 0) wait_idle();
      else begin
        for (int i = 0; i < 30 && (pend_q.size() != 0 || infl_q.size() != 0); i++) begin
          @(posedge clk); #2;
        end
      end
    end
    wait_idle();
    chk("drain", 32'(infl_q.size() + pend_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/control FSM that sits in front of the 32-bit combinational ALU.
- Accepts one MIPS-subset instruction per handshake, decodes it to the 3-bit ALU opcode, reads operands from the register file, and drives the ALU operand inputs.
- Samples the ALU result and issues a single-cycle register-file write-back.
- It is the initiator/consumer end of the ALU interface: it produces ALUOp/SrcDataA/SrcDataB and consumes result.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  block can accept; high only in IDLE.
- instr  input  32  MIPS instruction word.
- rs_addr  output  REG_AW  regfile read port A address.
- rt_addr  output  REG_AW  regfile read port B address.
- rs_data  input  DATA_W  regfile port A data; combinational, same cycle as address.
- rt_data  input  DATA_W  regfile port B data; combinational, same cycle as address.
- alu_op  output  3  ALU opcode.
- alu_a  output  DATA_W  ALU operand A.
- alu_b  output  DATA_W  ALU operand B.
- alu_result  input  DATA_W  ALU combinational result.
- wb_en  output  1  register-file write enable, one-cycle pulse.
- wb_addr  output  REG_AW  write-back destination register.
- wb_data  output  DATA_W  write-back value.
- done  output  1  one-cycle pulse, instruction retired.
- illegal  output  1  one-cycle pulse, unsupported instruction dropped.

Behaviour:
- Reset values: all outputs registered and reset to 0, except instr_ready = 1. State = IDLE.
- ALU opcode map: 000 add, 001 sub, 010 unsigned less-than, 011 signed less-than, 100 A<<B, 101 A>>B (logical), 110 or, 111 and.
- Decode, R-type (opcode 0), destination rd:
  - funct 0x20/0x21 -> 000.
  - funct 0x22/0x23 -> 001.
  - funct 0x2B -> 010.
  - funct 0x2A -> 011.
  - funct 0x25 -> 110.
  - funct 0x24 -> 111.
  - funct 0x00 (sll) -> 100, A = rt_data, B = zero-extended shamt.
  - funct 0x02 (srl) -> 101, A = rt_data, B = zero-extended shamt.
  - All other R-type: A = rs_data, B = rt_data.
- Decode, I-type, destination rt, A = rs_data:
  - 0x08/0x09 -> 000, B = sign-extended imm16.
  - 0x0A -> 011, B = sign-extended imm16.
  - 0x0B -> 010, B = sign-extended imm16 (compared unsigned).
  - 0x0D -> 110, B = zero-extended imm16.
  - 0x0C -> 111, B = zero-extended imm16.
  - Any other opcode/funct is illegal.
- Overflow is not trapped; add/sub wrap modulo 2^32.
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr, register rs_addr = instr[25:21] and rt_addr = instr[20:16], go to DECODE.
- DECODE: instr_ready = 0. Decode the latched instr and latch rs_data/rt_data.
  - Legal: compute alu_op/alu_a/alu_b registers, go to EXECUTE.
  - Illegal: pulse illegal in the following cycle, go to IDLE, no write-back.
- EXECUTE: alu_op/alu_a/alu_b are stable all cycle. Latch alu_result at the end of the cycle, go to WRITEBACK.
- WRITEBACK: wb_en = 1 for exactly one cycle with wb_addr/wb_data, done = 1, then go to IDLE.
- Destination $0: wb_en is forced 0, but done still pulses.
- Latency: accept edge T -> wb_en/done high in cycle T+3 -> instr_ready high again in cycle T+4. Throughput: one instruction per 4 cycles.
- alu_op/alu_a/alu_b hold their last values outside EXECUTE. The ALU output is not observed then.
- instr_valid while busy is ignored; the instruction is not consumed. instr is sampled only on the accept edge.
- done and illegal are never high in the same cycle.
- rst asserted in any state: next state IDLE, all outputs back to reset values, in-flight instruction discarded, no wb_en and no done.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_ADD..ALU_AND (3'b000..3'b111).
  - MIPS opcode/funct localparams.
  - State enum IDLE/DECODE/EXECUTE/WRITEBACK.
  - These are reused by the ALU and by future control units.
- One natural sub-module, alu_decode: purely combinational, instr -> {alu_op, a_sel, b_sel, ext_mode, dest_addr, legal}. The FSM and registers stay in alu_issue_ctrl.

Test Plan:
- Reset, then idle: instr_ready=1, wb_en=done=illegal=0, alu_op=0. Assert rst in EXECUTE of an add -> no wb_en ever, instr_ready=1 the next cycle.
- addu $3,$1,$2 with rs_data=0x00000005, rt_data=0xFFFFFFFF:
  - alu_op=000, alu_a=5, alu_b=0xFFFFFFFF in EXECUTE.
  - Model returns 4 -> wb_en=1, wb_addr=3, wb_data=4 exactly 3 cycles after accept.
- slti $4,$1,-1 with rs_data=0x80000000: alu_op=011, alu_b=0xFFFFFFFF, wb_data=1. ori with imm 0x8000: alu_b=0x00008000.
- sll $5,$2,4 with rt_data=0x1: alu_a=1, alu_b=4, alu_op=100, wb_addr=5.
- Illegal opcode 0x23 (lw): illegal pulses once, no wb_en, no done, instr_ready back within 2 cycles. addu targeting $0: done=1, wb_en=0.
- Back-to-back instr_valid held high for 3 instructions: exactly 3 accepts at 4-cycle spacing, instr_ready low while busy, results in issue order.
